pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Central stall/flush controller for the 5-stage RV32I pipeline.
- Watches the instructions in ID and EX, the EX-stage redirect, and the MEM-stage memory handshake.
- Drives the per-stage register enables and the active-low bubble-insert (flush) inputs of IF/ID and ID/EX.
- Keeps saturating stall and flush event counters for debug and performance.

Parameters:
- WB_LOAD, 2'b01: wb_sel encoding meaning "writeback from LSU load data".
- MEM_TIMEOUT, 16: cycles waiting for i_mem_ack before the access is abandoned; legal range 2..255.
- CNT_W, 16: width of the performance counters.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  reset.
- i_instr_id  in  32  instruction in the ID stage.
- i_instr_ex  in  32  instruction in the EX stage.
- i_rd_wren_ex  in  1  EX instruction writes rd.
- i_wb_sel_ex  in  2  EX instruction writeback select.
- i_pc_sel_ex  in  1  EX redirect (taken branch or jump).
- i_mem_req_mem  in  1  MEM-stage instruction accesses data memory.
- i_mem_ack  in  1  data memory completes the access this cycle.
- o_enable_if  out  1  PC and IF/ID register enable.
- o_enable_id  out  1  ID/EX register enable.
- o_enable_ex  out  1  EX/MEM register enable.
- o_enable_mem  out  1  MEM/WB register enable.
- o_flush_if_n  out  1  IF/ID bubble insert, active-low.
- o_flush_id_n  out  1  ID/EX bubble insert (NOP 0x00000013), active-low.
- o_mem_err  out  1  one-cycle pulse when a memory access times out.
- o_stall_cnt  out  CNT_W  saturating count of stall cycles.
- o_flush_cnt  out  CNT_W  saturating count of redirect flushes.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low.
  - While i_rst_n=0: state=RUN, wait counter=0, o_mem_err=0, o_stall_cnt=0, o_flush_cnt=0, all o_enable_*=0, o_flush_if_n=0, o_flush_id_n=0.
  - Reset mid-wait abandons the wait with no o_mem_err.
- Registered vs combinational: enable/flush outputs are combinational from the inputs and the state, so they act in the same cycle. o_mem_err and the counters are registered.
- FSM states:
  - RUN: normal flow.
  - MEM_WAIT: a memory access is outstanding.
- Decode of i_instr_id:
  - rs1 used unless opcode is 0110111, 0010111 or 1101111.
  - rs2 used only for opcodes 0110011, 0100011, 1100011.
- load_use = i_rd_wren_ex && i_wb_sel_ex==WB_LOAD && rd_ex!=0 && ((rs1 used && rs1_id==rd_ex) || (rs2 used && rs2_id==rd_ex)).
- mem_stall = i_mem_req_mem && !i_mem_ack, in RUN or MEM_WAIT.
- Priority, highest first: reset > mem_stall > redirect > load_use > normal.
  - mem_stall: all four enables=0, both flush_n=1 (whole pipe frozen). RUN->MEM_WAIT on the first such cycle.
  - redirect (i_pc_sel_ex=1, no mem_stall): all enables=1, o_flush_if_n=0, o_flush_id_n=0. The load_use check is ignored in the same cycle because the dependent instruction is squashed.
  - load_use: o_enable_if=0 (PC and IF/ID hold), o_flush_id_n=0 (bubble into EX), o_enable_id/ex/mem=1, o_flush_if_n=1. Lasts exactly one cycle, because the load advances to MEM.
  - normal: all enables=1, both flush_n=1.
- MEM_WAIT:
  - The wait counter increments each stalled cycle.
  - i_mem_ack=1: go to RUN, outputs normal in that cycle, counter clears.
  - Counter reaches MEM_TIMEOUT-1 without ack: the next cycle releases the pipe (outputs normal, access dropped), o_mem_err pulses for 1 cycle, state returns to RUN, counter=0.
  - i_mem_req_mem dropping while in MEM_WAIT: treated as ack.
- i_pc_sel_ex is ignored while mem_stall is active; it is acted on once the pipe unfreezes.
- Counters:
  - o_stall_cnt += 1 for each cycle with mem_stall or load_use.
  - o_flush_cnt += 1 for each redirect cycle that is acted on.
  - Both saturate at all-ones and do not wrap.

Test Plan:
- Load-use: EX = lw x5 (wb_sel 01, rd_wren 1), ID = add x6,x5,x7 (0x00728333) -> one cycle with o_enable_if=0 and o_flush_id_n=0; next cycle normal; o_stall_cnt=1.
- x0 and unused-rs cases: EX lw x0 with ID add x6,x0,x7 -> no stall; EX lw x5 with ID lui x5,0x1 -> no stall.
- Redirect beats load-use: i_pc_sel_ex=1 in the same cycle as a load-use match -> enables all 1, both flush_n=0; o_flush_cnt=1, o_stall_cnt=0.
- Memory wait: i_mem_req_mem=1, ack at cycle 3 -> three cycles of all enables 0, resume on the ack cycle; o_stall_cnt=3, o_mem_err never asserted.
- Timeout: with MEM_TIMEOUT=4, req held and ack never asserted -> 4 frozen cycles, then a normal cycle with a 1-cycle o_mem_err pulse; state returns to RUN.
- Reset: assert i_rst_n=0 asynchronously during MEM_WAIT -> outputs immediately go to their reset values, counters=0; after release, normal flow with no o_mem_err; counters saturate at 0xFFFF (force near-full via long stall).

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
//
// Central stall/flush controller for the 5-stage RV32I pipeline. Looks at the
// instructions sitting in ID and EX, the EX-stage redirect and the MEM-stage
// data-memory handshake, and decides every cycle whether the pipe advances,
// freezes, inserts a bubble or squashes the younger stages.
//
// Ports
//   i_clk          clock
//   i_rst_n        asynchronous active-low reset
//   i_instr_id     instruction currently in ID
//   i_instr_ex     instruction currently in EX
//   i_rd_wren_ex   EX instruction writes rd
//   i_wb_sel_ex    EX instruction writeback select
//   i_pc_sel_ex    EX redirect (taken branch / jump)
//   i_mem_req_mem  MEM-stage instruction accesses data memory
//   i_mem_ack      data memory completes the access this cycle
//   o_enable_if    PC and IF/ID register enable
//   o_enable_id    ID/EX register enable
//   o_enable_ex    EX/MEM register enable
//   o_enable_mem   MEM/WB register enable
//   o_flush_if_n   IF/ID bubble insert, active-low
//   o_flush_id_n   ID/EX bubble insert (NOP), active-low
//   o_mem_err      one-cycle pulse when a memory access is abandoned
//   o_stall_cnt    saturating count of stall cycles
//   o_flush_cnt    saturating count of acted-on redirects
//
// Enables and flushes are combinational so they act in the cycle the hazard
// is seen; o_mem_err and both counters are registered.
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl #(
  parameter logic [1:0] WB_LOAD     = 2'b01,
  parameter int         MEM_TIMEOUT = 16,
  parameter int         CNT_W       = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [31:0]      i_instr_id,
  input  logic [31:0]      i_instr_ex,
  input  logic             i_rd_wren_ex,
  input  logic [1:0]       i_wb_sel_ex,
  input  logic             i_pc_sel_ex,
  input  logic             i_mem_req_mem,
  input  logic             i_mem_ack,
  output logic             o_enable_if,
  output logic             o_enable_id,
  output logic             o_enable_ex,
  output logic             o_enable_mem,
  output logic             o_flush_if_n,
  output logic             o_flush_id_n,
  output logic             o_mem_err,
  output logic [CNT_W-1:0] o_stall_cnt,
  output logic [CNT_W-1:0] o_flush_cnt
);

  // RV32I opcodes that matter for register-use decode
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  // Last stalled cycle of a wait; the following cycle releases the pipe.
  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  typedef enum logic {
    ST_RUN,
    ST_MEM_WAIT
  } state_e;

  state_e           state_q, state_d;
  logic [7:0]       wait_cnt_q, wait_cnt_d;
  logic             mem_err_q, mem_err_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  // ---------------------------------------------------------------------------
  // Saturating increment: holds at all-ones instead of wrapping.
  // ---------------------------------------------------------------------------
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) begin
      return v;
    end
    return v + CNT_W'(1);
  endfunction

  // ---------------------------------------------------------------------------
  // Register-use decode of the ID instruction and destination of EX
  // ---------------------------------------------------------------------------
  logic [6:0] opc_id;
  logic [4:0] rs1_id;
  logic [4:0] rs2_id;
  logic [4:0] rd_ex;
  logic       rs1_used;
  logic       rs2_used;
  logic       load_use;

  assign opc_id = i_instr_id[6:0];
  assign rs1_id = i_instr_id[19:15];
  assign rs2_id = i_instr_id[24:20];
  assign rd_ex  = i_instr_ex[11:7];

  // Fields outside the register specifiers play no part in hazard detection.
  logic unused_instr_bits;
  assign unused_instr_bits = ^{i_instr_id[31:25], i_instr_id[14:7],
                               i_instr_ex[31:12], i_instr_ex[6:0]};

  assign rs1_used = (opc_id != OPC_LUI) && (opc_id != OPC_AUIPC) &&
                    (opc_id != OPC_JAL);
  assign rs2_used = (opc_id == OPC_OP) || (opc_id == OPC_STORE) ||
                    (opc_id == OPC_BRANCH);

  // A load result is not available until after MEM, so a consumer in ID must
  // wait one cycle. x0 is never a real dependency.
  assign load_use = i_rd_wren_ex && (i_wb_sel_ex == WB_LOAD) &&
                    (rd_ex != 5'd0) &&
                    ((rs1_used && (rs1_id == rd_ex)) ||
                     (rs2_used && (rs2_id == rd_ex)));

  // ---------------------------------------------------------------------------
  // Memory stall. In the cycle right after a timeout (mem_err_q high) the
  // stuck access is dropped, so the handshake is ignored for that one cycle
  // and the pipe is allowed to move.
  // ---------------------------------------------------------------------------
  logic mem_stall;
  logic redirect;
  logic lu_stall;

  assign mem_stall = i_mem_req_mem && !i_mem_ack && !mem_err_q;
  // A redirect seen while frozen is simply re-evaluated once the pipe moves,
  // because EX holds the same branch until then.
  assign redirect  = i_pc_sel_ex && !mem_stall;
  // The squash from a redirect removes the dependent instruction anyway.
  assign lu_stall  = load_use && !mem_stall && !i_pc_sel_ex;

  // ---------------------------------------------------------------------------
  // Next-state logic for the wait FSM and the registered outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    mem_err_d   = 1'b0;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;

    unique case (state_q)
      ST_RUN: begin
        if (mem_stall) begin
          state_d    = ST_MEM_WAIT;
          wait_cnt_d = 8'd1;
        end
      end
      ST_MEM_WAIT: begin
        if (!mem_stall) begin
          // ack, or the request went away: either way the access is over
          state_d    = ST_RUN;
          wait_cnt_d = 8'd0;
        end else if (wait_cnt_q == WAIT_LAST) begin
          // give up; the release cycle carries the error pulse
          state_d    = ST_RUN;
          wait_cnt_d = 8'd0;
          mem_err_d  = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      default: begin
        state_d    = ST_RUN;
        wait_cnt_d = 8'd0;
      end
    endcase

    if (mem_stall || lu_stall) begin
      stall_cnt_d = sat_inc(stall_cnt_q);
    end
    if (redirect) begin
      flush_cnt_d = sat_inc(flush_cnt_q);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ST_RUN;
      wait_cnt_q  <= 8'd0;
      mem_err_q   <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      mem_err_q   <= mem_err_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage enables and bubble inserts, priority: reset > mem_stall > redirect >
  // load-use > normal.
  // ---------------------------------------------------------------------------
  always_comb begin
    o_enable_if  = 1'b1;
    o_enable_id  = 1'b1;
    o_enable_ex  = 1'b1;
    o_enable_mem = 1'b1;
    o_flush_if_n = 1'b1;
    o_flush_id_n = 1'b1;

    if (!i_rst_n) begin
      o_enable_if  = 1'b0;
      o_enable_id  = 1'b0;
      o_enable_ex  = 1'b0;
      o_enable_mem = 1'b0;
      o_flush_if_n = 1'b0;
      o_flush_id_n = 1'b0;
    end else if (mem_stall) begin
      // whole pipe frozen, nothing squashed
      o_enable_if  = 1'b0;
      o_enable_id  = 1'b0;
      o_enable_ex  = 1'b0;
      o_enable_mem = 1'b0;
    end else if (redirect) begin
      // wrong-path instructions in IF and ID become bubbles
      o_flush_if_n = 1'b0;
      o_flush_id_n = 1'b0;
    end else if (lu_stall) begin
      // hold PC and IF/ID, send a bubble into EX while the load moves on
      o_enable_if  = 1'b0;
      o_flush_id_n = 1'b0;
    end
  end

  assign o_mem_err   = mem_err_q;
  assign o_stall_cnt = stall_cnt_q;
  assign o_flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

  localparam logic [5:0] C_NORM = 6'b111111;
  localparam logic [5:0] C_FRZ  = 6'b000011;
  localparam logic [5:0] C_RDR  = 6'b111100;
  localparam logic [5:0] C_LU   = 6'b011110;
  localparam logic [5:0] C_RST  = 6'b000000;

  localparam logic [31:0] LW_X5     = 32'h0000A283;
  localparam logic [31:0] LW_X0     = 32'h0000A003;
  localparam logic [31:0] ADD_X5    = 32'h002082B3;
  localparam logic [31:0] ADD_D5    = 32'h00728333;
  localparam logic [31:0] ADD_D0    = 32'h00700333;
  localparam logic [31:0] LUI_X5    = 32'h000012B7;
  localparam logic [31:0] LUI_R5    = 32'h00028337;
  localparam logic [31:0] ADDI_R2_5 = 32'h00508313;
  localparam logic [31:0] SW_X5     = 32'h00512023;

  logic        i_clk;
  logic        i_rst_n;
  logic [31:0] i_instr_id;
  logic [31:0] i_instr_ex;
  logic        i_rd_wren_ex;
  logic [1:0]  i_wb_sel_ex;
  logic        i_pc_sel_ex;
  logic        i_mem_req_mem;
  logic        i_mem_ack;
  logic        o_enable_if;
  logic        o_enable_id;
  logic        o_enable_ex;
  logic        o_enable_mem;
  logic        o_flush_if_n;
  logic        o_flush_id_n;
  logic        o_mem_err;
  logic [15:0] o_stall_cnt;
  logic [15:0] o_flush_cnt;

  pipe_hazard_ctrl #(
    .WB_LOAD    (2'b01),
    .MEM_TIMEOUT(4),
    .CNT_W      (16)
  ) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_instr_id   (i_instr_id),
    .i_instr_ex   (i_instr_ex),
    .i_rd_wren_ex (i_rd_wren_ex),
    .i_wb_sel_ex  (i_wb_sel_ex),
    .i_pc_sel_ex  (i_pc_sel_ex),
    .i_mem_req_mem(i_mem_req_mem),
    .i_mem_ack    (i_mem_ack),
    .o_enable_if  (o_enable_if),
    .o_enable_id  (o_enable_id),
    .o_enable_ex  (o_enable_ex),
    .o_enable_mem (o_enable_mem),
    .o_flush_if_n (o_flush_if_n),
    .o_flush_id_n (o_flush_id_n),
    .o_mem_err    (o_mem_err),
    .o_stall_cnt  (o_stall_cnt),
    .o_flush_cnt  (o_flush_cnt)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [5:0]  ctrl;
    logic        err;
    logic [15:0] scnt;
    logic [15:0] fcnt;
    int          id;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   step_no = 0;

  // Monitor: one expectation per stimulus cycle, compared mid-cycle.
  always @(negedge i_clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      logic [5:0] act;
      e   = exp_q.pop_front();
      act = {o_enable_if, o_enable_id, o_enable_ex, o_enable_mem,
             o_flush_if_n, o_flush_id_n};
      checks++;
      if (act !== e.ctrl) begin
        errors++;
        $display("FAIL step%0d ctrl got %b want %b", e.id, act, e.ctrl);
      end
      checks++;
      if (o_mem_err !== e.err) begin
        errors++;
        $display("FAIL step%0d mem_err got %b want %b", e.id, o_mem_err, e.err);
      end
      checks++;
      if (o_stall_cnt !== e.scnt) begin
        errors++;
        $display("FAIL step%0d stall_cnt got %0d want %0d", e.id, o_stall_cnt, e.scnt);
      end
      checks++;
      if (o_flush_cnt !== e.fcnt) begin
        errors++;
        $display("FAIL step%0d flush_cnt got %0d want %0d", e.id, o_flush_cnt, e.fcnt);
      end
    end
  end

  task automatic drive(input logic [31:0] id, input logic [31:0] ex,
                       input logic wren, input logic [1:0] wbsel,
                       input logic pcsel, input logic req, input logic ack);
    i_instr_id    = id;
    i_instr_ex    = ex;
    i_rd_wren_ex  = wren;
    i_wb_sel_ex   = wbsel;
    i_pc_sel_ex   = pcsel;
    i_mem_req_mem = req;
    i_mem_ack     = ack;
  endtask

  task automatic step(input logic [31:0] id, input logic [31:0] ex,
                      input logic wren, input logic [1:0] wbsel,
                      input logic pcsel, input logic req, input logic ack,
                      input logic [5:0] ctrl, input logic err,
                      input logic [15:0] scnt, input logic [15:0] fcnt);
    exp_t e;
    drive(id, ex, wren, wbsel, pcsel, req, ack);
    step_no++;
    e.ctrl = ctrl;
    e.err  = err;
    e.scnt = scnt;
    e.fcnt = fcnt;
    e.id   = step_no;
    exp_q.push_back(e);
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at step%0d", step_no);
    $fatal(1, "watchdog");
  end

  initial begin
    i_rst_n = 1'b0;
    drive(32'h0, 32'h0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    @(posedge i_clk);
    #1;
    // 1: in reset
    step(32'h0, 32'h0, 0, 2'b00, 0, 0, 0, C_RST, 0, 0, 0);
    i_rst_n = 1'b1;
    // 2: idle
    step(32'h0, 32'h0, 0, 2'b00, 0, 0, 0, C_NORM, 0, 0, 0);
    // 3-4: load-use then normal
    step(ADD_D5, LW_X5, 1, 2'b01, 0, 0, 0, C_LU, 0, 0, 0);
    step(32'h0, ADD_D5, 1, 2'b00, 0, 0, 0, C_NORM, 0, 1, 0);
    // 5-8: x0 and unused-source cases
    step(ADD_D0, LW_X0, 1, 2'b01, 0, 0, 0, C_NORM, 0, 1, 0);
    step(LUI_X5, LW_X5, 1, 2'b01, 0, 0, 0, C_NORM, 0, 1, 0);
    step(LUI_R5, LW_X5, 1, 2'b01, 0, 0, 0, C_NORM, 0, 1, 0);
    step(ADDI_R2_5, LW_X5, 1, 2'b01, 0, 0, 0, C_NORM, 0, 1, 0);
    // 9: rs2 dependency of a store
    step(SW_X5, LW_X5, 1, 2'b01, 0, 0, 0, C_LU, 0, 1, 0);
    // 10-11: not a load / no rd write
    step(ADD_D5, ADD_X5, 1, 2'b00, 0, 0, 0, C_NORM, 0, 2, 0);
    step(ADD_D5, LW_X5, 0, 2'b01, 0, 0, 0, C_NORM, 0, 2, 0);
    // 12-13: redirect beats load-use
    step(ADD_D5, LW_X5, 1, 2'b01, 1, 0, 0, C_RDR, 0, 2, 0);
    step(32'h0, 32'h0, 0, 2'b00, 0, 0, 0, C_NORM, 0, 2, 1);
    // 14-18: memory wait, ack in the 4th cycle; redirect held off until then
    step(32'h0, 32'h0, 0, 2'b00, 0, 1, 0, C_FRZ, 0, 2, 1);
    step(32'h0, 32'h0, 0, 2'b00, 0, 1, 0, C_FRZ, 0, 3, 1);
    step(32'h0, 32'h0, 0, 2'b00, 1, 1, 0, C_FRZ, 0, 4, 1);
    step(32'h0, 32'h0, 0, 2'b00, 1, 1, 1, C_RDR, 0, 5, 1);
    step(32'h0, 32'h0, 0, 2'b00, 0, 0, 0, C_NORM, 0, 5, 2);
    // 19-21: request dropped while waiting acts as ack
    step(32'h0, 32'h0, 0, 2'b00, 0, 1, 0, C_FRZ, 0, 5, 2);
    step(32'h0, 32'h0, 0, 2'b00, 0, 0, 0, C_NORM, 0, 6, 2);
    step(32'h0, 32'h0, 0, 2'b00, 0, 1, 1, C_NORM, 0, 6, 2);
    // 22-26: timeout after 4 frozen cycles, release cycle carries mem_err
    step(32'h0, 32'h0, 0, 2'b00, 0, 1, 0, C_FRZ, 0, 6, 2);
    step(32'h0, 32'h0, 0, 2'b00, 0, 1, 0, C_FRZ, 0, 7, 2);
    step(32'h0, 32'h0, 0, 2'b00, 0, 1, 0, C_FRZ, 0, 8, 2);
    step(32'h0, 32'h0, 0, 2'b00, 0, 1, 0, C_FRZ, 0, 9, 2);
    step(32'h0, 32'h0, 0, 2'b00, 0, 1, 0, C_NORM, 1, 10, 2);
    // 27-28: back in RUN, a new wait starts
    step(32'h0, 32'h0, 0, 2'b00, 0, 1, 0, C_FRZ, 0, 10, 2);
    step(32'h0, 32'h0, 0, 2'b00, 0, 1, 0, C_FRZ, 0, 11, 2);
    // 29-30: asynchronous reset in the middle of the wait
    i_rst_n = 1'b0;
    step(32'h0, 32'h0, 0, 2'b00, 0, 1, 0, C_RST, 0, 0, 0);
    step(32'h0, 32'h0, 0, 2'b00, 0, 1, 0, C_RST, 0, 0, 0);
    i_rst_n = 1'b1;
    // 31-37: no error after release; wait counter starts fresh
    step(32'h0, 32'h0, 0, 2'b00, 0, 0, 0, C_NORM, 0, 0, 0);
    step(32'h0, 32'h0, 0, 2'b00, 0, 1, 0, C_FRZ, 0, 0, 0);
    step(32'h0, 32'h0, 0, 2'b00, 0, 1, 0, C_FRZ, 0, 1, 0);
    step(32'h0, 32'h0, 0, 2'b00, 0, 1, 0, C_FRZ, 0, 2, 0);
    step(32'h0, 32'h0, 0, 2'b00, 0, 1, 0, C_FRZ, 0, 3, 0);
    step(32'h0, 32'h0, 0, 2'b00, 0, 1, 0, C_NORM, 1, 4, 0);
    step(32'h0, 32'h0, 0, 2'b00, 0, 0, 0, C_NORM, 0, 4, 0);
    // long load-use hold fills the stall counter to exactly 0xFFFF
    drive(ADD_D5, LW_X5, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0);
    repeat (65531) begin
      @(posedge i_clk);
      #1;
    end
    step(ADD_D5, LW_X5, 1, 2'b01, 0, 0, 0, C_LU, 0, 16'hFFFF, 0);
    step(ADD_D5, LW_X5, 1, 2'b01, 0, 0, 0, C_LU, 0, 16'hFFFF, 0);
    step(32'h0, 32'h0, 0, 2'b00, 1, 0, 0, C_RDR, 0, 16'hFFFF, 0);
    step(32'h0, 32'h0, 0, 2'b00, 0, 0, 0, C_NORM, 0, 16'hFFFF, 1);

    for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(negedge i_clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending %0d want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
